// File: rtl/pmem_arbiter.sv
// pmem_arbiter
// Shares the single physical-memory port between the instruction cache and
// the data cache. One requester is granted at a time; its address (and, for
// the data cache, its write line) is captured into registered pmem_* outputs
// and held until memory answers. The answer is steered back to the granted
// cache only. Simultaneous requests are granted round-robin.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_read, i_address         I-cache line read request / address
//   i_rdata, i_resp           line and one-cycle completion to the I-cache
//   d_read, d_write           D-cache line read / writeback request
//   d_address, d_wdata        D-cache line address / writeback line
//   d_rdata, d_resp           line and one-cycle completion to the D-cache
//   pmem_read, pmem_write     registered downstream request
//   pmem_address, pmem_wdata  registered downstream address / write line
//   pmem_rdata, pmem_resp     downstream read line / completion
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    lastD_q, lastD_d;
    logic                    pmemRead_q, pmemRead_d;
    logic                    pmemWrite_q, pmemWrite_d;
    logic [ADDR_WIDTH-1:0]   pmemAddress_q, pmemAddress_d;
    logic [LINE_WIDTH-1:0]   pmemWdata_q, pmemWdata_d;

    logic iReq;
    logic dReq;

    assign iReq = i_read;
    assign dReq = d_read | d_write;

    // State and captured downstream request. Reset abandons any transaction
    // in flight, so the downstream request drops without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            lastD_q       <= 1'b1;
            pmemRead_q    <= 1'b0;
            pmemWrite_q   <= 1'b0;
            pmemAddress_q <= '0;
            pmemWdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            lastD_q       <= lastD_d;
            pmemRead_q    <= pmemRead_d;
            pmemWrite_q   <= pmemWrite_d;
            pmemAddress_q <= pmemAddress_d;
            pmemWdata_q   <= pmemWdata_d;
        end
    end

    // Grant and completion logic. Requests are only looked at in IDLE; while
    // serving, everything holds until pmem_resp, so requester changes
    // mid-transaction have no effect. lastD_q breaks ties: after the D-cache
    // was served the I-cache wins, and vice versa.
    always_comb begin
        state_d       = state_q;
        lastD_d       = lastD_q;
        pmemRead_d    = pmemRead_q;
        pmemWrite_d   = pmemWrite_q;
        pmemAddress_d = pmemAddress_q;
        pmemWdata_d   = pmemWdata_q;

        case (state_q)
            IDLE: begin
                if (iReq && (!dReq || lastD_q)) begin
                    state_d       = SERVE_I;
                    pmemAddress_d = i_address;
                    pmemRead_d    = 1'b1;
                    pmemWrite_d   = 1'b0;
                end else if (dReq) begin
                    // A writeback takes priority if the D-cache raises both.
                    state_d       = SERVE_D;
                    pmemAddress_d = d_address;
                    pmemWdata_d   = d_wdata;
                    pmemWrite_d   = d_write;
                    pmemRead_d    = ~d_write;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_d     = IDLE;
                    lastD_d     = 1'b0;
                    pmemRead_d  = 1'b0;
                    pmemWrite_d = 1'b0;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_d     = IDLE;
                    lastD_d     = 1'b1;
                    pmemRead_d  = 1'b0;
                    pmemWrite_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                pmemRead_d  = 1'b0;
                pmemWrite_d = 1'b0;
            end
        endcase
    end

    // Completion is forwarded combinationally, and only to the cache that
    // owns the current transaction; a stray pmem_resp in IDLE goes nowhere.
    assign i_resp = (state_q == SERVE_I) && pmem_resp;
    assign d_resp = (state_q == SERVE_D) && pmem_resp;

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    assign pmem_read    = pmemRead_q;
    assign pmem_write   = pmemWrite_q;
    assign pmem_address = pmemAddress_q;
    assign pmem_wdata   = pmemWdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter
// Directed bench for pmem_arbiter. Inputs change 1 ns after each rising
// edge; outputs are sampled 1 ns after that, or 1 ns after a combinational
// stimulus change when checking the pass-through response path.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int compared;
    int mismatched;

    pmem_arbiter #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full downstream request in one go.
    task automatic checkRequest(input string tag, input logic expRead,
                                input logic expWrite, input logic [AW-1:0] expAddr);
        checkOutput({tag, ".pmem_read"}, LW'(pmem_read), LW'(expRead));
        checkOutput({tag, ".pmem_write"}, LW'(pmem_write), LW'(expWrite));
        checkOutput({tag, ".pmem_address"}, LW'(pmem_address), LW'(expAddr));
    endtask

    // Raise pmem_resp with a line and check where the response is steered.
    task automatic applyStimulus(input string tag, input logic [LW-1:0] line,
                                 input logic expI, input logic expD);
        pmem_resp  = 1'b1;
        pmem_rdata = line;
        #1;
        checkOutput({tag, ".i_resp"}, LW'(i_resp), LW'(expI));
        checkOutput({tag, ".d_resp"}, LW'(d_resp), LW'(expD));
        if (expI) checkOutput({tag, ".i_rdata"}, i_rdata, line);
        if (expD) checkOutput({tag, ".d_rdata"}, d_rdata, line);
    endtask

    initial begin
        logic [LW-1:0] lineA5;
        logic [LW-1:0] line1234;
        logic [LW-1:0] lineOther;
        logic [LW-1:0] lineC3;

        compared   = 0;
        mismatched = 0;
        lineA5     = {32{8'hA5}};
        line1234   = {8{32'h1234_5678}};
        lineOther  = {8{32'hDEAD_BEEF}};
        lineC3     = {32{8'hC3}};

        rst        = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        tick();
        tick();
        checkRequest("por", 1'b0, 1'b0, 32'h0);
        checkOutput("por.pmem_wdata", pmem_wdata, '0);
        rst = 1'b0;

        // Asynchronous reset in the middle of a D writeback.
        d_write   = 1'b1;
        d_address = 32'h0000_1000;
        d_wdata   = line1234;
        tick();
        checkRequest("rstD.grant", 1'b0, 1'b1, 32'h0000_1000);
        #2;
        pmem_resp = 1'b1;
        rst       = 1'b1;
        #1;
        checkRequest("rstD.async", 1'b0, 1'b0, 32'h0);
        checkOutput("rstD.pmem_wdata", pmem_wdata, '0);
        checkOutput("rstD.d_resp", LW'(d_resp), LW'(1'b0));
        checkOutput("rstD.i_resp", LW'(i_resp), LW'(1'b0));
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        tick();
        rst = 1'b0;

        // pmem_resp in IDLE must not reach either cache.
        pmem_resp = 1'b1;
        #1;
        checkOutput("idleResp.i_resp", LW'(i_resp), LW'(1'b0));
        checkOutput("idleResp.d_resp", LW'(d_resp), LW'(1'b0));
        pmem_resp = 1'b0;
        tick();

        // Single I read, memory answers in the fifth cycle.
        i_read    = 1'b1;
        i_address = 32'h0000_0060;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checkRequest($sformatf("iRead.c%0d", c), 1'b1, 1'b0, 32'h0000_0060);
            checkOutput($sformatf("iRead.c%0d.i_resp", c), LW'(i_resp), LW'(1'b0));
        end
        tick();
        checkRequest("iRead.c5", 1'b1, 1'b0, 32'h0000_0060);
        applyStimulus("iRead.done", lineA5, 1'b1, 1'b0);
        tick();
        pmem_resp = 1'b0;
        i_read    = 1'b0;
        #1;
        checkRequest("iRead.idle", 1'b0, 1'b0, 32'h0000_0060);
        checkOutput("iRead.idle.i_resp", LW'(i_resp), LW'(1'b0));

        // D writeback; changing d_wdata mid-transaction must not leak through.
        d_write   = 1'b1;
        d_address = 32'h0000_1000;
        d_wdata   = line1234;
        tick();
        checkRequest("dWb.grant", 1'b0, 1'b1, 32'h0000_1000);
        checkOutput("dWb.wdata0", pmem_wdata, line1234);
        d_wdata   = lineOther;
        d_address = 32'h0000_2000;
        tick();
        tick();
        checkRequest("dWb.hold", 1'b0, 1'b1, 32'h0000_1000);
        checkOutput("dWb.wdata2", pmem_wdata, line1234);
        applyStimulus("dWb.done", '0, 1'b0, 1'b1);
        tick();
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        #1;
        checkRequest("dWb.idle", 1'b0, 1'b0, 32'h0000_1000);

        // Read and write raised together: the write wins.
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'h0000_3000;
        d_wdata   = lineC3;
        tick();
        checkRequest("rw.grant", 1'b0, 1'b1, 32'h0000_3000);
        checkOutput("rw.wdata", pmem_wdata, lineC3);
        applyStimulus("rw.done", '0, 1'b0, 1'b1);
        tick();
        pmem_resp = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;

        // Reset two cycles into an I read; the read restarts afterwards.
        i_read    = 1'b1;
        i_address = 32'h0000_0080;
        tick();
        checkRequest("rstI.grant", 1'b1, 1'b0, 32'h0000_0080);
        tick();
        tick();
        pmem_resp = 1'b1;
        rst       = 1'b1;
        #1;
        checkRequest("rstI.async", 1'b0, 1'b0, 32'h0);
        checkOutput("rstI.i_resp", LW'(i_resp), LW'(1'b0));
        pmem_resp = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkRequest("rstI.regrant", 1'b1, 1'b0, 32'h0000_0080);
        applyStimulus("rstI.done", lineA5, 1'b1, 1'b0);
        tick();
        pmem_resp = 1'b0;
        i_read    = 1'b0;

        // Contention from reset: the last grant above went to I, so only a
        // correctly reset tie-breaker gives I the first turn here.
        rst       = 1'b1;
        i_read    = 1'b1;
        i_address = 32'h0000_0200;
        d_read    = 1'b1;
        d_address = 32'h0000_0300;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            logic servingI;
            logic [AW-1:0] expAddr;
            servingI = (t % 2) == 0;
            expAddr  = servingI ? 32'h0000_0200 : 32'h0000_0300;
            tick();
            checkRequest($sformatf("rr%0d.grant", t), 1'b1, 1'b0, expAddr);
            tick();
            checkRequest($sformatf("rr%0d.hold", t), 1'b1, 1'b0, expAddr);
            applyStimulus($sformatf("rr%0d.done", t), lineC3, servingI, !servingI);
            tick();
            pmem_resp = 1'b0;
            #1;
            checkRequest($sformatf("rr%0d.gap", t), 1'b0, 1'b0, expAddr);
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
